// File: rtl/alu_pkg.sv
// ============================================================================
// Module      : alu_pkg
// Description : Shared definitions for the sequential ALU: operation codes,
//               relation codes and FSM state encoding.
// Contents    : OP_*  - 5-bit operation codes
//               REL_* - 2-bit in1-versus-in2 relation codes
//               ST_*  - 2-bit controller state encoding
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package alu_pkg;

    // Operation codes; every code not listed here produces result = 0.
    localparam logic [4:0] OP_AND = 5'd0;
    localparam logic [4:0] OP_OR  = 5'd1;
    localparam logic [4:0] OP_ADD = 5'd2;
    localparam logic [4:0] OP_SUB = 5'd3;
    localparam logic [4:0] OP_SLT = 5'd4;
    localparam logic [4:0] OP_NOR = 5'd5;
    localparam logic [4:0] OP_XOR = 5'd6;
    localparam logic [4:0] OP_SLL = 5'd7;
    localparam logic [4:0] OP_SRL = 5'd8;
    localparam logic [4:0] OP_SRA = 5'd9;
    localparam logic [4:0] OP_MUL = 5'd10;
    localparam logic [4:0] OP_DIV = 5'd11;

    // Relation of in1 to in2.
    localparam logic [1:0] REL_LT = 2'b00;
    localparam logic [1:0] REL_GT = 2'b01;
    localparam logic [1:0] REL_EQ = 2'b10;

    // Controller states.
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_MUL  = 2'd1;
    localparam logic [1:0] ST_DIV  = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    // True for operations that run on the iterative datapath.
    function automatic logic is_long_op(input logic [4:0] op);
        return (op == OP_MUL) || (op == OP_DIV);
    endfunction

endpackage

`default_nettype wire

// File: rtl/alu_if.sv
// ============================================================================
// Module      : alu_if
// Description : Handshake and operand/result bundle between the EX stage
//               control (master) and the sequential ALU (slave).
// Signals     : flush, in_valid, op, sign, in1, in2, out_ready  (master -> slave)
//               in_ready, out_valid, result, result_hi,
//               relation, busy                              (slave -> master)
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface alu_if #(
    parameter int WIDTH = 32
) ();
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [4:0]       op;
    logic             sign;
    logic [WIDTH-1:0] in1;
    logic [WIDTH-1:0] in2;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic [WIDTH-1:0] result_hi;
    logic [1:0]       relation;
    logic             busy;

    modport master (
        output flush, in_valid, op, sign, in1, in2, out_ready,
        input  in_ready, out_valid, result, result_hi, relation, busy
    );

    modport slave (
        input  flush, in_valid, op, sign, in1, in2, out_ready,
        output in_ready, out_valid, result, result_hi, relation, busy
    );
endinterface

`default_nettype wire

// File: rtl/alu_iter_core.sv
// ============================================================================
// Module      : alu_iter_core
// Description : WIDTH-step iterative datapath shared by unsigned shift-add
//               multiply and unsigned restoring divide. Operands are
//               magnitudes; sign handling is done by the caller.
// Ports       : clk, reset      - clock, asynchronous active-high reset
//               start_i         - load operands and begin a new operation
//               abort_i         - drop the running operation
//               is_div_i        - 1 = divide, 0 = multiply (sampled at start)
//               a_i, b_i        - multiplier/dividend, multiplicand/divisor
//               done_o          - final step is being computed this cycle
//               hi_o, lo_o      - step output: product hi/lo or rem/quotient
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_iter_core #(
    parameter  int WIDTH = 32,
    localparam int SHW   = $clog2(WIDTH)
) (
    input  wire logic             clk,
    input  wire logic             reset,
    input  wire logic             start_i,
    input  wire logic             abort_i,
    input  wire logic             is_div_i,
    input  wire logic [WIDTH-1:0] a_i,
    input  wire logic [WIDTH-1:0] b_i,
    output logic                  done_o,
    output logic [WIDTH-1:0]      hi_o,
    output logic [WIDTH-1:0]      lo_o
);

    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic [WIDTH-1:0] b_q;
    logic             is_div_q;
    logic             active_q;
    logic [SHW-1:0]   cnt_q;

    logic [WIDTH:0]   w_sum;
    logic [WIDTH:0]   w_shift;
    logic [WIDTH-1:0] w_sub;

    always_comb begin
        // Multiply: conditional add of the multiplicand into the high half.
        w_sum   = {1'b0, hi_q} + {1'b0, b_q};
        // Divide: partial remainder shifted left with the next dividend bit.
        w_shift = {hi_q, lo_q[WIDTH-1]};
        // The kept difference is always below the divisor, so the low WIDTH
        // bits of the subtraction are exact.
        w_sub   = w_shift[WIDTH-1:0] - b_q;

        hi_d = hi_q;
        lo_d = lo_q;
        if (is_div_q) begin
            if (w_shift >= {1'b0, b_q}) begin
                hi_d = w_sub;
                lo_d = {lo_q[WIDTH-2:0], 1'b1};
            end else begin
                hi_d = w_shift[WIDTH-1:0];
                lo_d = {lo_q[WIDTH-2:0], 1'b0};
            end
        end else begin
            // The multiplier is consumed from lo's LSB while product bits
            // shift in from the top.
            if (lo_q[0]) begin
                {hi_d, lo_d} = {w_sum, lo_q[WIDTH-1:1]};
            end else begin
                {hi_d, lo_d} = {1'b0, hi_q, lo_q[WIDTH-1:1]};
            end
        end
    end

    assign done_o = active_q && (cnt_q == SHW'(WIDTH - 1));
    assign hi_o   = hi_d;
    assign lo_o   = lo_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hi_q     <= '0;
            lo_q     <= '0;
            b_q      <= '0;
            is_div_q <= 1'b0;
            active_q <= 1'b0;
            cnt_q    <= '0;
        end else if (abort_i) begin
            active_q <= 1'b0;
        end else if (start_i) begin
            hi_q     <= '0;
            lo_q     <= a_i;
            b_q      <= b_i;
            is_div_q <= is_div_i;
            active_q <= 1'b1;
            cnt_q    <= '0;
        end else if (active_q) begin
            hi_q  <= hi_d;
            lo_q  <= lo_d;
            cnt_q <= cnt_q + 1'b1;
            if (done_o) begin
                active_q <= 1'b0;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/alu_seq.sv
// ============================================================================
// Module      : alu_seq
// Description : Multi-cycle EX-stage ALU. Logic, arithmetic, compare and
//               shift operations complete in one registered cycle; MUL and
//               DIV iterate for WIDTH cycles. Valid/ready on both sides,
//               synchronous flush aborts any in-flight work.
// Ports       : clk    - clock, rising edge
//               reset  - asynchronous active-high reset
//               bus    - alu_if slave: flush, in_valid/in_ready, op, sign,
//                        in1, in2, out_valid/out_ready, result, result_hi,
//                        relation, busy
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_seq
    import alu_pkg::*;
#(
    parameter  int WIDTH = 32,
    localparam int SHW   = $clog2(WIDTH)
) (
    input wire logic clk,
    input wire logic reset,
    alu_if.slave     bus
);

    logic [1:0]       state_q,     state_d;
    logic [WIDTH-1:0] result_q,    result_d;
    logic [WIDTH-1:0] result_hi_q, result_hi_d;
    logic [1:0]       relation_q,  relation_d;
    logic             neg_x_q,     neg_x_d;    // negate product / quotient
    logic             neg_r_q,     neg_r_d;    // negate remainder
    logic             div0_q,      div0_d;
    logic [WIDTH-1:0] in1_q,       in1_d;      // dividend kept for divide-by-zero

    logic             w_in_ready;
    logic             w_accept;
    logic [SHW-1:0]   w_shamt;
    logic             w_lt;
    logic [1:0]       w_rel;
    logic [WIDTH-1:0] w_single;
    logic             w_neg1, w_neg2;
    logic [WIDTH-1:0] w_mag1, w_mag2;
    logic             w_core_done;
    logic [WIDTH-1:0] w_core_hi, w_core_lo;
    logic [2*WIDTH-1:0] w_prod, w_prod_fix;
    logic [WIDTH-1:0] w_quo, w_rem;

    assign w_in_ready = (state_q == ST_IDLE) || ((state_q == ST_DONE) && bus.out_ready);
    // Flush wins over any acceptance in the same cycle.
    assign w_accept   = bus.in_valid && w_in_ready && !bus.flush;

    // ---------------------------------------------------------------- single-cycle ops
    assign w_shamt = bus.in1[SHW-1:0];
    assign w_lt    = bus.sign ? ($signed(bus.in1) < $signed(bus.in2)) : (bus.in1 < bus.in2);
    assign w_rel   = (bus.in1 == bus.in2) ? REL_EQ : (w_lt ? REL_LT : REL_GT);

    always_comb begin
        w_single = '0;
        case (bus.op)
            OP_AND: w_single = bus.in1 & bus.in2;
            OP_OR:  w_single = bus.in1 | bus.in2;
            OP_ADD: w_single = bus.in1 + bus.in2;
            OP_SUB: w_single = bus.in1 - bus.in2;
            OP_SLT: w_single = {{(WIDTH-1){1'b0}}, w_lt};
            OP_NOR: w_single = ~(bus.in1 | bus.in2);
            OP_XOR: w_single = bus.in1 ^ bus.in2;
            OP_SLL: w_single = bus.in2 << w_shamt;
            OP_SRL: w_single = bus.in2 >> w_shamt;
            OP_SRA: w_single = $signed(bus.in2) >>> w_shamt;
            default: w_single = '0;
        endcase
    end

    // ---------------------------------------------------------------- iterative ops
    assign w_neg1 = bus.sign && bus.in1[WIDTH-1];
    assign w_neg2 = bus.sign && bus.in2[WIDTH-1];
    assign w_mag1 = w_neg1 ? (-bus.in1) : bus.in1;
    assign w_mag2 = w_neg2 ? (-bus.in2) : bus.in2;

    alu_iter_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .clk      (clk),
        .reset    (reset),
        .start_i  (w_accept && is_long_op(bus.op)),
        .abort_i  (bus.flush),
        .is_div_i (bus.op == OP_DIV),
        .a_i      (w_mag1),
        .b_i      (w_mag2),
        .done_o   (w_core_done),
        .hi_o     (w_core_hi),
        .lo_o     (w_core_lo)
    );

    assign w_prod     = {w_core_hi, w_core_lo};
    assign w_prod_fix = neg_x_q ? (-w_prod) : w_prod;
    // MIN / -1 falls out naturally: magnitude 2^(WIDTH-1) with no negation.
    assign w_quo      = div0_q ? '1    : (neg_x_q ? (-w_core_lo) : w_core_lo);
    assign w_rem      = div0_q ? in1_q : (neg_r_q ? (-w_core_hi) : w_core_hi);

    // ---------------------------------------------------------------- controller
    always_comb begin
        state_d     = state_q;
        result_d    = result_q;
        result_hi_d = result_hi_q;
        relation_d  = relation_q;
        neg_x_d     = neg_x_q;
        neg_r_d     = neg_r_q;
        div0_d      = div0_q;
        in1_d       = in1_q;

        if (bus.flush) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (w_accept) begin
                        relation_d = w_rel;
                        neg_x_d    = w_neg1 ^ w_neg2;
                        neg_r_d    = w_neg1;
                        div0_d     = (bus.in2 == '0);
                        in1_d      = bus.in1;
                        if (bus.op == OP_MUL) begin
                            state_d = ST_MUL;
                        end else if (bus.op == OP_DIV) begin
                            state_d = ST_DIV;
                        end else begin
                            state_d     = ST_DONE;
                            result_d    = w_single;
                            result_hi_d = '0;
                        end
                    end else if (state_q == ST_DONE && bus.out_ready) begin
                        state_d = ST_IDLE;
                    end
                end
                ST_MUL: begin
                    if (w_core_done) begin
                        state_d                 = ST_DONE;
                        {result_hi_d, result_d} = w_prod_fix;
                    end
                end
                ST_DIV: begin
                    if (w_core_done) begin
                        state_d     = ST_DONE;
                        result_d    = w_quo;
                        result_hi_d = w_rem;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            result_q    <= '0;
            result_hi_q <= '0;
            relation_q  <= REL_EQ;
            neg_x_q     <= 1'b0;
            neg_r_q     <= 1'b0;
            div0_q      <= 1'b0;
            in1_q       <= '0;
        end else begin
            state_q     <= state_d;
            result_q    <= result_d;
            result_hi_q <= result_hi_d;
            relation_q  <= relation_d;
            neg_x_q     <= neg_x_d;
            neg_r_q     <= neg_r_d;
            div0_q      <= div0_d;
            in1_q       <= in1_d;
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = (state_q == ST_DONE);
    assign bus.busy      = (state_q == ST_MUL) || (state_q == ST_DIV);
    assign bus.result    = result_q;
    assign bus.result_hi = result_hi_q;
    assign bus.relation  = relation_q;

endmodule

`default_nettype wire

// File: tb/tb_alu_seq.sv
// ============================================================================
// Module      : tb_alu_seq
// Description : Self-checking bench for alu_seq (WIDTH = 32): directed vector
//               table, randomized operations against an arithmetic reference
//               model, and hand-written backpressure/flush/reset sequences.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_alu_seq;

    localparam int W = 32;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    alu_if #(.WIDTH(W)) bus ();

    alu_seq #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [4:0]   op;
        logic         sg;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] r;
        logic [W-1:0] rh;
        logic [1:0]   rel;
    } vec_t;

    vec_t tbl[21];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model computed with 64-bit integer arithmetic.
    function automatic void model(input logic [4:0] op, input logic sg,
                                  input logic [W-1:0] a, input logic [W-1:0] b,
                                  output logic [W-1:0] r, output logic [W-1:0] rh,
                                  output logic [1:0] rel);
        longint va, vb;
        logic [63:0] p;
        logic [63:0] q;
        logic [63:0] m;
        logic signed [W-1:0] bs;
        logic [4:0] n;
        va = sg ? longint'($signed(a)) : longint'({32'h0, a});
        vb = sg ? longint'($signed(b)) : longint'({32'h0, b});
        rel = (va == vb) ? 2'b10 : ((va < vb) ? 2'b00 : 2'b01);
        n  = a[4:0];
        bs = b;
        r  = '0;
        rh = '0;
        case (op)
            5'd0:  r = a & b;
            5'd1:  r = a | b;
            5'd2:  r = a + b;
            5'd3:  r = a - b;
            5'd4:  r = (va < vb) ? 32'd1 : 32'd0;
            5'd5:  r = ~(a | b);
            5'd6:  r = a ^ b;
            5'd7:  r = b << n;
            5'd8:  r = b >> n;
            5'd9:  r = bs >>> n;
            5'd10: begin
                p  = va * vb;
                r  = p[31:0];
                rh = p[63:32];
            end
            5'd11: begin
                if (b == '0) begin
                    r  = '1;
                    rh = a;
                end else begin
                    q  = va / vb;
                    m  = va % vb;
                    r  = q[31:0];
                    rh = m[31:0];
                end
            end
            default: ;
        endcase
    endfunction

    // Issue one operation from IDLE, wait for the result, then consume it.
    task automatic run_op(input logic [4:0] op, input logic sg,
                          input logic [W-1:0] a, input logic [W-1:0] b,
                          output logic [W-1:0] r, output logic [W-1:0] rh,
                          output logic [1:0] rel, output int lat, output int bcnt);
        bus.op        = op;
        bus.sign      = sg;
        bus.in1       = a;
        bus.in2       = b;
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.in1      = $urandom;   // operands must already be latched
        bus.in2      = $urandom;
        lat  = 1;
        bcnt = 0;
        while (!bus.out_valid && lat < 100) begin
            if (bus.busy) bcnt++;
            @(posedge clk);
            @(negedge clk);
            lat++;
        end
        r   = bus.result;
        rh  = bus.result_hi;
        rel = bus.relation;
        bus.out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.out_ready = 1'b0;
    endtask

    function automatic logic [W-1:0] pick();
        case ($urandom_range(0, 5))
            0:       return 32'h0;
            1:       return 32'h8000_0000;
            2:       return 32'hFFFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [W-1:0] r, rh, er, erh, hold_r;
        logic [1:0]   rel, erel;
        int           lat, bcnt, elat;
        logic [4:0]   op;
        logic         sg;
        logic [W-1:0] a, b;

        bus.flush     = 1'b0;
        bus.in_valid  = 1'b0;
        bus.op        = '0;
        bus.sign      = 1'b0;
        bus.in1       = '0;
        bus.in2       = '0;
        bus.out_ready = 1'b0;

        // ------------------------------------------------ reset state
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_result",    bus.result,    0);
        check("rst_result_hi", bus.result_hi, 0);
        check("rst_relation",  bus.relation,  2'b10);
        check("rst_busy",      bus.busy,      0);
        check("rst_in_ready",  bus.in_ready,  1);

        // ------------------------------------------------ directed table
        tbl[0]  = '{5'd2,  1'b0, 32'hFFFF_FFFF, 32'h1,         32'h0,         32'h0,         2'b01};
        tbl[1]  = '{5'd2,  1'b1, 32'hFFFF_FFFF, 32'h1,         32'h0,         32'h0,         2'b00};
        tbl[2]  = '{5'd10, 1'b1, 32'hFFFF_FFFD, 32'h7,         32'hFFFF_FFEB, 32'hFFFF_FFFF, 2'b00};
        tbl[3]  = '{5'd10, 1'b0, 32'hFFFF_FFFF, 32'h2,         32'hFFFF_FFFE, 32'h1,         2'b01};
        tbl[4]  = '{5'd11, 1'b1, 32'hFFFF_FFF9, 32'h2,         32'hFFFF_FFFD, 32'hFFFF_FFFF, 2'b00};
        tbl[5]  = '{5'd11, 1'b0, 32'h1234_5678, 32'h0,         32'hFFFF_FFFF, 32'h1234_5678, 2'b01};
        tbl[6]  = '{5'd11, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0,         2'b00};
        tbl[7]  = '{5'd9,  1'b0, 32'd36,        32'h8000_0000, 32'hF800_0000, 32'h0,         2'b00};
        tbl[8]  = '{5'd4,  1'b1, 32'hFFFF_FFFF, 32'h0,         32'h1,         32'h0,         2'b00};
        tbl[9]  = '{5'd4,  1'b0, 32'hFFFF_FFFF, 32'h0,         32'h0,         32'h0,         2'b01};
        tbl[10] = '{5'd7,  1'b0, 32'h4,         32'h1,         32'h10,        32'h0,         2'b01};
        tbl[11] = '{5'd8,  1'b0, 32'h21,        32'h8000_0000, 32'h4000_0000, 32'h0,         2'b00};
        tbl[12] = '{5'd3,  1'b0, 32'h5,         32'h5,         32'h0,         32'h0,         2'b10};
        tbl[13] = '{5'd14, 1'b0, 32'h5,         32'h3,         32'h0,         32'h0,         2'b01};
        tbl[14] = '{5'd11, 1'b1, 32'hFFFF_FFF9, 32'h0,         32'hFFFF_FFFF, 32'hFFFF_FFF9, 2'b00};
        tbl[15] = '{5'd11, 1'b1, 32'h7,         32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'h1,         2'b01};
        tbl[16] = '{5'd5,  1'b0, 32'h0F0F_0000, 32'h0000_0F0F, 32'hF0F0_F0F0, 32'h0,         2'b01};
        tbl[17] = '{5'd6,  1'b0, 32'hAAAA_5555, 32'hFFFF_0000, 32'h5555_5555, 32'h0,         2'b00};
        tbl[18] = '{5'd0,  1'b0, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'h00F0_00F0, 32'h0,         2'b01};
        tbl[19] = '{5'd1,  1'b0, 32'h1,         32'h2,         32'h3,         32'h0,         2'b00};
        tbl[20] = '{5'd10, 1'b1, 32'h8000_0000, 32'h8000_0000, 32'h0,         32'h4000_0000, 2'b10};

        for (int i = 0; i < 21; i++) begin
            run_op(tbl[i].op, tbl[i].sg, tbl[i].a, tbl[i].b, r, rh, rel, lat, bcnt);
            elat = (tbl[i].op == 5'd10 || tbl[i].op == 5'd11) ? W + 1 : 1;
            check($sformatf("tbl%0d_result", i),    r,    tbl[i].r);
            check($sformatf("tbl%0d_result_hi", i), rh,   tbl[i].rh);
            check($sformatf("tbl%0d_relation", i),  rel,  tbl[i].rel);
            check($sformatf("tbl%0d_latency", i),   lat,  elat);
            check($sformatf("tbl%0d_busy_cycles", i), bcnt, elat - 1);
        end

        // ------------------------------------------------ randomized vs model
        for (int i = 0; i < 150; i++) begin
            op = 5'($urandom_range(0, 13));
            sg = 1'($urandom_range(0, 1));
            a  = pick();
            b  = pick();
            model(op, sg, a, b, er, erh, erel);
            run_op(op, sg, a, b, r, rh, rel, lat, bcnt);
            elat = (op == 5'd10 || op == 5'd11) ? W + 1 : 1;
            check($sformatf("rnd%0d_op%0d_result", i, op),    r,   er);
            check($sformatf("rnd%0d_op%0d_result_hi", i, op), rh,  erh);
            check($sformatf("rnd%0d_op%0d_relation", i, op),  rel, erel);
            check($sformatf("rnd%0d_op%0d_latency", i, op),   lat, elat);
        end

        // ------------------------------------------------ backpressure and back-to-back
        bus.op = 5'd10; bus.sign = 1'b0; bus.in1 = 32'hFFFF_FFFF; bus.in2 = 32'h2;
        bus.in_valid = 1'b1; bus.out_ready = 1'b0;
        @(posedge clk); @(negedge clk);
        bus.in_valid = 1'b0;
        lat = 1;
        while (!bus.out_valid && lat < 100) begin
            @(posedge clk); @(negedge clk);
            lat++;
        end
        check("bp_latency", lat, W + 1);
        for (int k = 0; k < 5; k++) begin
            check($sformatf("bp_hold%0d_result", k),    bus.result,    32'hFFFF_FFFE);
            check($sformatf("bp_hold%0d_result_hi", k), bus.result_hi, 32'h1);
            check($sformatf("bp_hold%0d_out_valid", k), bus.out_valid, 1);
            check($sformatf("bp_hold%0d_in_ready", k),  bus.in_ready,  0);
            @(posedge clk); @(negedge clk);
        end
        bus.out_ready = 1'b1;
        bus.op = 5'd2; bus.in1 = 32'd5; bus.in2 = 32'd6; bus.in_valid = 1'b1;
        #1;
        check("bp_in_ready_with_out_ready", bus.in_ready, 1);
        @(posedge clk); @(negedge clk);
        check("b2b_add1_out_valid", bus.out_valid, 1);
        check("b2b_add1_result",    bus.result,    32'd11);
        check("b2b_add1_result_hi", bus.result_hi, 32'd0);
        bus.in1 = 32'd7; bus.in2 = 32'd8;
        @(posedge clk); @(negedge clk);
        check("b2b_add2_out_valid", bus.out_valid, 1);
        check("b2b_add2_result",    bus.result,    32'd15);
        bus.in_valid = 1'b0;
        @(posedge clk); @(negedge clk);
        check("b2b_drain_out_valid", bus.out_valid, 0);
        bus.out_ready = 1'b0;

        // ------------------------------------------------ flush during DIV
        bus.op = 5'd11; bus.sign = 1'b1; bus.in1 = 32'hFFFF_FFF9; bus.in2 = 32'h2;
        bus.in_valid = 1'b1;
        @(posedge clk); @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (8) begin
            @(posedge clk); @(negedge clk);
        end
        check("flush_pre_busy", bus.busy, 1);
        hold_r = bus.result;
        bus.flush = 1'b1; bus.in_valid = 1'b1;
        bus.op = 5'd2; bus.in1 = 32'd1; bus.in2 = 32'd1;
        @(posedge clk); @(negedge clk);
        bus.flush = 1'b0; bus.in_valid = 1'b0;
        check("flush_busy",      bus.busy,      0);
        check("flush_out_valid", bus.out_valid, 0);
        check("flush_in_ready",  bus.in_ready,  1);
        check("flush_stale_result", bus.result, hold_r);
        repeat (3) begin
            @(posedge clk); @(negedge clk);
        end
        check("flush_ignored_valid", bus.out_valid, 0);
        run_op(5'd4, 1'b1, 32'hFFFF_FFFF, 32'h0, r, rh, rel, lat, bcnt);
        check("post_flush_slt_result",  r,   32'd1);
        check("post_flush_slt_latency", lat, 1);

        // ------------------------------------------------ asynchronous reset mid-MUL
        bus.op = 5'd10; bus.sign = 1'b0; bus.in1 = 32'd3; bus.in2 = 32'd5;
        bus.in_valid = 1'b1;
        @(posedge clk); @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (5) begin
            @(posedge clk); @(negedge clk);
        end
        check("rstmul_pre_busy",     bus.busy,     1);
        check("rstmul_pre_relation", bus.relation, 2'b00);
        #1 reset = 1'b1;
        #1;
        check("rstmul_out_valid", bus.out_valid, 0);
        check("rstmul_relation",  bus.relation,  2'b10);
        check("rstmul_busy",      bus.busy,      0);
        check("rstmul_result",    bus.result,    0);
        check("rstmul_in_ready",  bus.in_ready,  1);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        run_op(5'd10, 1'b0, 32'd3, 32'd5, r, rh, rel, lat, bcnt);
        check("post_rst_mul_result",  r,   32'd15);
        check("post_rst_mul_latency", lat, W + 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Parameterised, multi-cycle successor of the pipeline's single-cycle ALU.
- Executes the existing logic, arithmetic, compare and shift operations in one registered cycle.
- Adds iterative multiply (hi/lo product) and iterative divide (quotient/remainder).
- Sits in the EX stage behind a valid/ready handshake so the hazard unit can stall on long operations; flush discards in-flight work.

Parameters:
WIDTH, 32, datapath width in bits (power of two, >= 8)
SHW, $clog2(WIDTH), shift-amount width, derived

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high reset
flush  in  1  synchronous abort of any in-flight operation
in_valid  in  1  operands/op presented
in_ready  out  1  block can accept (state IDLE, or DONE with out_ready high)
op  in  5  operation code (see Behaviour)
sign  in  1  1 = signed interpretation for SLT, MUL, DIV and relation
in1  in  WIDTH  operand A (shift amount for shifts)
in2  in  WIDTH  operand B (value shifted for shifts)
out_valid  out  1  result registers hold a completed operation
out_ready  in  1  consumer takes result this cycle
result  out  WIDTH  primary result (product low / quotient)
result_hi  out  WIDTH  product high / remainder; 0 for single-cycle ops
relation  out  2  in1 vs in2: 00 less, 01 greater, 10 equal; signedness per sign
busy  out  1  MUL or DIV iteration in progress

Behaviour:
- Reset: state IDLE; out_valid=0, result=0, result_hi=0, relation=2'b10, busy=0; in_ready=1.
- Op codes: 0 AND, 1 OR, 2 ADD, 3 SUB, 4 SLT, 5 NOR, 6 XOR, 7 SLL, 8 SRL, 9 SRA, 10 MUL, 11 DIV; all other codes return result=0.
- Shifts use in1[SHW-1:0] only; SRA replicates in2[WIDTH-1].
- SLT is a true signed compare when sign=1, unsigned when sign=0.
- Acceptance: an operation is accepted when in_valid && in_ready.
- States:
  - IDLE: accepting a single-cycle op goes to DONE; the result appears the next cycle with out_valid=1 (latency 1).
  - IDLE: accepting MUL goes to MUL; accepting DIV goes to DIV. busy=1 in both.
  - MUL: shift-add over |operands|, one bit per cycle, WIDTH cycles. Sign-fix the 2*WIDTH product, then go to DONE. Latency WIDTH+1.
  - DIV: restoring division, one bit per cycle, WIDTH cycles. Quotient sign = xor of operand signs; remainder takes the sign of in1. Then go to DONE. Latency WIDTH+1.
  - DONE: outputs held stable while out_valid && !out_ready.
    - out_ready with no new accept: go to IDLE, out_valid=0 next cycle.
    - out_ready with a simultaneous accept: start the new op directly (back-to-back single-cycle throughput 1/cycle).
- relation is captured at accept and presented with the result.
- Divide by zero: quotient all ones, remainder=in1; still WIDTH+1 latency, no exception.
- Signed overflow (MIN / -1): quotient=MIN, remainder=0.
- flush:
  - Any state goes to IDLE next edge; out_valid=0, busy=0. result/result_hi keep stale values.
  - in_valid in the flush cycle is ignored.
  - flush has priority over acceptance and over out_ready.
- Operands are latched at accept; input changes during MUL/DIV have no effect.
- reset mid-operation: immediate return to reset values (asynchronous).
- ADD/SUB wrap modulo 2^WIDTH; no overflow flag.

Decomposition:
- Shared package alu_pkg: op-code localparams (AND..DIV), relation codes (REL_LT=00, REL_GT=01, REL_EQ=10), FSM state encoding (IDLE, MUL, DIV, DONE).
- One sub-module, alu_iter_core: shared WIDTH-cycle shift/add-subtract datapath for MUL and DIV, with start/done and a cycle counter. Single-cycle ops and handshake/FSM stay in alu_seq.

Test Plan:
- ADD, WIDTH=32: in1=0xFFFF_FFFF, in2=1, op=2 -> one cycle later out_valid=1, result=0, result_hi=0. relation (sign=0) = 01; with sign=1 (-1 vs 1) = 00.
- Signed MUL: in1=-3, in2=7, sign=1 -> after 33 cycles {result_hi,result}=0xFFFF_FFFF_FFFF_FFEB, busy high 32 cycles. Unsigned 0xFFFF_FFFF*2 -> hi=1, lo=0xFFFF_FFFE.
- Signed DIV: in1=-7, in2=2 -> quotient 0xFFFF_FFFD (-3), remainder 0xFFFF_FFFF (-1). in2=0 -> quotient 0xFFFF_FFFF, remainder=in1. 0x8000_0000 / -1 -> quotient 0x8000_0000, remainder 0.
- Backpressure: MUL completes with out_ready=0 for 5 cycles -> result stable, in_ready=0. out_ready=1 with a simultaneous valid ADD -> ADD result on the next cycle, no bubble.
- flush on cycle 10 of a DIV -> next cycle state IDLE, busy=0, out_valid=0. A following SLT in1=-1, in2=0, sign=1 returns 1.
- Shifts: SRA in1=36, in2=0x8000_0000 -> uses shamt 4, result 0xF800_0000. Asserting reset during MUL -> out_valid=0, relation=10 immediately, without waiting for a clock.
